// File: rtl/pixel_plot_sink.sv
// Plot-request sink: queues (x, y, colour) requests, converts them to linear framebuffer
// addresses and drives a grant-handshaked write port; also runs full-screen clear sweeps.
// Optional statistics counters are built when PLOT_SINK_STATS_EN is defined.
module pixel_plot_sink #(
  parameter int DEPTH = 8,
  parameter int H_RES = 320,
  parameter int V_RES = 240
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        plot_valid,
  output logic        plot_ready,
  input  logic [8:0]  plot_x,
  input  logic [7:0]  plot_y,
  input  logic [2:0]  plot_colour,
  input  logic        clear_req,
  input  logic [2:0]  clear_colour,
  output logic        fb_we,
  input  logic        fb_grant,
  output logic [16:0] fb_addr,
  output logic [2:0]  fb_data,
  output logic        idle,
  output logic [15:0] drop_count,
  output logic [15:0] write_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [16:0] LAST_ADDR = 17'(H_RES * V_RES - 1);

  typedef enum logic {RUN, CLEAR} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   occ_q, occ_d;
  logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [19:0]     mem_q [DEPTH];
  logic            a_valid_q, a_valid_d;
  logic [19:0]     a_entry_q, a_entry_d;
  logic            we_q, we_d;
  logic [16:0]     addr_q, addr_d;
  logic [2:0]      data_q, data_d;
  logic            clr_pend_q, clr_pend_d;
  logic [2:0]      clr_col_q, clr_col_d;

  logic            in_range;
  logic [16:0]     plot_addr;
  logic            accept;
  logic            push_a;
  logic            wr_done;
  logic            run_done;
  logic            fifo_push;
  logic            fifo_pop;
  logic            clear_start;

  // occ_q counts every accepted in-range pixel not yet written: address stage,
  // FIFO and output register together, so plot_ready drops once DEPTH are in flight.
  assign in_range    = ({1'b0, plot_x} < 10'(H_RES)) && ({1'b0, plot_y} < 9'(V_RES));
  assign plot_addr   = 17'(plot_y) * 17'(H_RES) + 17'(plot_x);
  assign plot_ready  = resetn && (state_q == RUN) && !clr_pend_q && (occ_q != CW'(DEPTH));
  assign accept      = plot_valid && plot_ready;
  assign push_a      = accept && in_range;
  assign wr_done     = we_q && fb_grant;
  assign run_done    = wr_done && (state_q == RUN);
  assign fifo_push   = a_valid_q;
  assign fifo_pop    = (state_q == RUN) && (fifo_cnt_q != '0) && (!we_q || fb_grant);
  assign clear_start = (state_q == RUN) && clr_pend_q && (occ_q == '0);

  always_comb begin
    state_d    = state_q;
    occ_d      = occ_q + CW'(push_a) - CW'(run_done);
    fifo_cnt_d = fifo_cnt_q + CW'(fifo_push) - CW'(fifo_pop);
    wr_ptr_d   = wr_ptr_q + PW'(fifo_push);
    rd_ptr_d   = rd_ptr_q + PW'(fifo_pop);
    a_valid_d  = push_a;
    a_entry_d  = push_a ? {plot_addr, plot_colour} : a_entry_q;
    clr_pend_d = clr_pend_q;
    clr_col_d  = clr_col_q;
    we_d       = we_q;
    addr_d     = addr_q;
    data_d     = data_q;

    case (state_q)
      RUN: begin
        if (clear_req && !clr_pend_q) begin
          clr_pend_d = 1'b1;
          clr_col_d  = clear_colour;
        end
        if (fifo_pop) begin
          we_d             = 1'b1;
          {addr_d, data_d} = mem_q[rd_ptr_q];
        end else if (wr_done) begin
          we_d = 1'b0;
        end
        if (clear_start) begin
          state_d    = CLEAR;
          clr_pend_d = 1'b0;
          we_d       = 1'b1;
          addr_d     = '0;
          data_d     = clr_col_q;
        end
      end
      CLEAR: begin
        if (wr_done) begin
          if (addr_q == LAST_ADDR) begin
            we_d    = 1'b0;
            state_d = RUN;
          end else begin
            addr_d = addr_q + 17'd1;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= RUN;
      occ_q      <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      a_valid_q  <= 1'b0;
      a_entry_q  <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      clr_pend_q <= 1'b0;
      clr_col_q  <= '0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      a_valid_q  <= a_valid_d;
      a_entry_q  <= a_entry_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      clr_pend_q <= clr_pend_d;
      clr_col_q  <= clr_col_d;
    end
  end

  always_ff @(posedge clock) begin
    if (resetn && fifo_push) begin
      mem_q[wr_ptr_q] <= a_entry_q;
    end
  end

  assign fb_we   = we_q;
  assign fb_addr = addr_q;
  assign fb_data = data_q;
  assign idle    = (occ_q == '0) && (state_q == RUN) && !clr_pend_q;

`ifdef PLOT_SINK_STATS_EN
  logic        drop;
  logic [15:0] drop_q;
  logic [15:0] wcnt_q;

  assign drop = accept && !in_range;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      drop_q <= '0;
      wcnt_q <= '0;
    end else begin
      if (drop && (drop_q != '1)) drop_q <= drop_q + 16'd1;
      if (wr_done && (wcnt_q != '1)) wcnt_q <= wcnt_q + 16'd1;
    end
  end

  assign drop_count  = drop_q;
  assign write_count = wcnt_q;
`else
  assign drop_count  = '0;
  assign write_count = '0;
`endif

endmodule

// File: tb/tb_pixel_plot_sink.sv
// Scoreboard bench for pixel_plot_sink: stimulus queues expected {addr, colour} writes,
// a negedge monitor pops and compares on every granted framebuffer write.
module tb_pixel_plot_sink;

`ifdef PLOT_SINK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        plot_valid = 1'b0;
  logic        plot_ready;
  logic [8:0]  plot_x = '0;
  logic [7:0]  plot_y = '0;
  logic [2:0]  plot_colour = '0;
  logic        clear_req = 1'b0;
  logic [2:0]  clear_colour = '0;
  logic        fb_we;
  logic        fb_grant = 1'b0;
  logic [16:0] fb_addr;
  logic [2:0]  fb_data;
  logic        idle;
  logic [15:0] drop_count;
  logic [15:0] write_count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [19:0] exp_q [$];
  logic [19:0] mon_e;

  pixel_plot_sink #(.DEPTH(8), .H_RES(320), .V_RES(240)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .plot_valid   (plot_valid),
    .plot_ready   (plot_ready),
    .plot_x       (plot_x),
    .plot_y       (plot_y),
    .plot_colour  (plot_colour),
    .clear_req    (clear_req),
    .clear_colour (clear_colour),
    .fb_we        (fb_we),
    .fb_grant     (fb_grant),
    .fb_addr      (fb_addr),
    .fb_data      (fb_data),
    .idle         (idle),
    .drop_count   (drop_count),
    .write_count  (write_count)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (resetn && fb_we && fb_grant) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected: got addr=%0d data=%0d, expected no write", fb_addr, fb_data);
      end else begin
        mon_e = exp_q.pop_front();
        if ({fb_addr, fb_data} !== mon_e) begin
          n_bad++;
          $display("FAIL sb_write: got addr=%0d data=%0d, expected addr=%0d data=%0d",
                   fb_addr, fb_data, mon_e[19:3], mon_e[2:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic set_plot(input int x, input int y, input int c, input bit exp_write);
    plot_valid  = 1'b1;
    plot_x      = 9'(x);
    plot_y      = 8'(y);
    plot_colour = 3'(c);
    if (exp_write) exp_q.push_back({17'(y * 320 + x), 3'(c)});
  endtask

  task automatic wait_idle(input string name, input int bound);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (idle) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  initial begin
    bit ready_seen;
    logic        p_we, p_g;
    logic [16:0] p_addr;
    logic [2:0]  p_data;

    // Reset state
    repeat (3) tick();
    chk("rst_we", 32'(fb_we), 0);
    chk("rst_addr", 32'(fb_addr), 0);
    chk("rst_data", 32'(fb_data), 0);
    chk("rst_idle", 32'(idle), 1);
    chk("rst_ready", 32'(plot_ready), 0);
    resetn = 1'b1;
    tick();
    chk("ready_after_rst", 32'(plot_ready), 1);

    // Single plot, latency of two edges
    fb_grant = 1'b1;
    set_plot(5, 2, 5, 1'b1);
    tick();
    plot_valid = 1'b0;
    chk("lat_e0_we", 32'(fb_we), 0);
    tick();
    chk("lat_e1_we", 32'(fb_we), 0);
    tick();
    chk("lat_e2_we", 32'(fb_we), 1);
    chk("lat_e2_addr", 32'(fb_addr), 645);
    chk("lat_e2_data", 32'(fb_data), 5);
    tick();
    chk("single_we_off", 32'(fb_we), 0);
    chk("single_idle", 32'(idle), 1);

    // Fill with grant low
    fb_grant = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("fill_ready_hi", 32'(plot_ready), 1);
      set_plot(10 + i, 1, i, 1'b1);
      tick();
    end
    plot_valid = 1'b0;
    chk("fill_ready_lo", 32'(plot_ready), 0);
    repeat (3) tick();
    chk("fill_ready_still_lo", 32'(plot_ready), 0);
    chk("fill_head_we", 32'(fb_we), 1);
    chk("fill_head_addr", 32'(fb_addr), 330);
    fb_grant = 1'b1;
    wait_idle("fill_drain_idle", 40);
    chk("fill_sb_empty", 32'(exp_q.size()), 0);

    // Out-of-range requests
    set_plot(320, 0, 1, 1'b0);
    tick();
    set_plot(0, 240, 2, 1'b0);
    tick();
    plot_valid = 1'b0;
    repeat (4) tick();
    chk("oor_idle", 32'(idle), 1);
    chk("oor_drop_count", 32'(drop_count), STATS ? 2 : 0);

    // Bottom-right corner
    set_plot(319, 239, 6, 1'b1);
    tick();
    plot_valid = 1'b0;
    wait_idle("corner_idle", 10);
    chk("corner_sb_empty", 32'(exp_q.size()), 0);
    chk("wcount_pre_clear", 32'(write_count), STATS ? 10 : 0);

    // Clear with three pixels queued, counters restarted
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    fb_grant = 1'b0;
    tick();
    set_plot(100, 100, 1, 1'b1);
    tick();
    set_plot(200, 50, 2, 1'b1);
    tick();
    set_plot(319, 0, 4, 1'b1);
    tick();
    plot_valid   = 1'b0;
    clear_req    = 1'b1;
    clear_colour = 3'd7;
    tick();
    clear_req    = 1'b0;
    clear_colour = 3'd0;
    chk("clr_pend_ready", 32'(plot_ready), 0);
    chk("clr_pend_idle", 32'(idle), 0);
    for (int a = 0; a < 76800; a++) exp_q.push_back({17'(a), 3'd7});
    fb_grant   = 1'b1;
    ready_seen = 1'b0;
    for (int i = 0; i < 77000; i++) begin
      if (idle) break;
      if (plot_ready) ready_seen = 1'b1;
      tick();
    end
    chk("clr_ready_low", 32'(ready_seen), 0);
    chk("clr_done_idle", 32'(idle), 1);
    chk("clr_sb_empty", 32'(exp_q.size()), 0);
    chk("clr_write_count", 32'(write_count), STATS ? 76803 : 0);
    chk("clr_drop_count", 32'(drop_count), 0);

    // Grant toggling while streaming
    for (int c = 0; c < 16; c++) begin
      fb_grant = (c % 2 == 0);
      if (c < 4) set_plot(c, 10, c + 1, 1'b1);
      else plot_valid = 1'b0;
      p_we = fb_we;
      p_g = fb_grant;
      p_addr = fb_addr;
      p_data = fb_data;
      tick();
      if (p_we && !p_g) begin
        chk("stall_we", 32'(fb_we), 1);
        chk("stall_addr", 32'(fb_addr), 32'(p_addr));
        chk("stall_data", 32'(fb_data), 32'(p_data));
      end
    end
    plot_valid = 1'b0;
    fb_grant = 1'b1;
    wait_idle("toggle_idle", 20);
    chk("toggle_sb_empty", 32'(exp_q.size()), 0);

    // Reset in the middle of a clear
    fb_grant     = 1'b0;
    clear_req    = 1'b1;
    clear_colour = 3'd3;
    tick();
    clear_req    = 1'b0;
    clear_colour = 3'd0;
    tick();
    chk("mid_clr_we", 32'(fb_we), 1);
    chk("mid_clr_addr", 32'(fb_addr), 0);
    chk("mid_clr_data", 32'(fb_data), 3);
    chk("mid_clr_ready", 32'(plot_ready), 0);
    for (int a = 0; a < 5; a++) exp_q.push_back({17'(a), 3'd3});
    fb_grant = 1'b1;
    repeat (5) tick();
    fb_grant = 1'b0;
    chk("mid_clr_addr5", 32'(fb_addr), 5);
    resetn = 1'b0;
    tick();
    chk("mid_rst_we", 32'(fb_we), 0);
    chk("mid_rst_addr", 32'(fb_addr), 0);
    chk("mid_rst_idle", 32'(idle), 1);
    chk("mid_rst_sb_empty", 32'(exp_q.size()), 0);
    resetn = 1'b1;
    tick();
    fb_grant = 1'b1;
    set_plot(7, 3, 6, 1'b1);
    tick();
    plot_valid = 1'b0;
    wait_idle("post_rst_idle", 10);
    chk("post_rst_sb_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pixel_plot_sink.md
# pixel_plot_sink

Consumer end of the draw/erase pixel stream. Accepts one plot request (x, y, 3-bit colour) per cycle from the drawing controller, buffers requests in a small FIFO, and converts each one into a linear framebuffer write address. It then drives the framebuffer write port, which has a grant-based handshake. It also offers a full-screen clear sweep, and reports when every accepted pixel has been committed so the controller can safely signal frame completion.

## Interface
Parameters:
- DEPTH, 8: FIFO entries; power of two, 2..32.
- H_RES, 320: visible width; x ≥ H_RES is out of range.
- V_RES, 240: visible height; y ≥ V_RES is out of range.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- resetn  in  1  synchronous, active-low reset.
- plot_valid  in  1  plot request present.
- plot_ready  out  1  request accepted when plot_valid && plot_ready.
- plot_x  in  9  pixel column.
- plot_y  in  8  pixel row.
- plot_colour  in  3  pixel colour.
- clear_req  in  1  single-cycle pulse; start a full-screen fill.
- clear_colour  in  3  fill colour, sampled with clear_req.
- fb_we  out  1  framebuffer write request.
- fb_grant  in  1  write completes in any cycle where fb_we && fb_grant.
- fb_addr  out  17  linear address, y*H_RES + x.
- fb_data  out  3  write colour.
- idle  out  1  FIFO empty, no write pending, not clearing.
- drop_count  out  16  out-of-range requests dropped (only with PLOT_SINK_STATS_EN).
- write_count  out  16  completed framebuffer writes (only with PLOT_SINK_STATS_EN).

## Operation
- FSM states: RUN (the reset state), CLEAR.
- Reset values: fb_we=0, fb_addr=0, fb_data=0, idle=1, plot_ready=0 while resetn=0, FIFO empty, counters=0, state=RUN.
- RUN, input side:
  - plot_ready = (FIFO count != DEPTH).
  - An accepted in-range request is pushed as {addr, colour}.
  - An accepted out-of-range request is consumed but never pushed; drop_count increments.
  - Address computed as (y<<8) + (y<<6) + x, 17-bit, no truncation; max 76799.
- RUN, output side:
  - The output stage is one register holding fb_we/fb_addr/fb_data.
  - It loads the FIFO head when it is empty or its current write is granted in the same cycle (pop and reload on one edge).
  - fb_addr and fb_data hold stable while fb_we=1 and fb_grant=0.
- Push and pop in the same cycle: count is unchanged, legal at any count below DEPTH. At count=DEPTH, plot_ready=0 regardless of pop (no full bypass).
- Clear request:
  - clear_req in RUN is honoured only once the FIFO is empty and the output stage has no pending write.
  - The request is latched as clear_pending until those conditions hold. plot_ready=0 while clear_pending or in CLEAR.
  - clear_colour is captured in the cycle clear_req=1.
- CLEAR state:
  - Sweeps fb_addr 0..H_RES*V_RES-1 with fb_data=captured colour; the address advances only on grant.
  - After the grant of the last address, return to RUN.
  - clear_req while already in CLEAR or pending is ignored.
- idle = FIFO empty && no pending write && state=RUN && !clear_pending.
- Reset mid-operation: FIFO flushed, pending write abandoned, clear aborted, outputs to reset values at that edge.

## Timing
- Accept at edge N → fb_we=1 with that pixel after edge N+2, when the pipeline was empty.
- Throughput with fb_grant held high: 1 pixel/cycle sustained.
- plot_ready is combinational from registered count and state only; no path from plot_valid.
- A clear with a constant grant takes H_RES*V_RES cycles (76800 by default) plus 2 cycles of entry/exit overhead.
- idle rises the cycle after the final grant.

## Configuration
- PLOT_SINK_STATS_EN defined:
  - drop_count and write_count are implemented; both saturate at 16'hFFFF and reset to 0.
  - write_count counts every completed write, including clear writes.
- PLOT_SINK_STATS_EN undefined: both ports are tied to 0 and no counter logic is synthesised; all other behaviour is identical.

## Test plan
- Single plot (x=5, y=2, colour=3'b101), fb_grant=1 → one fb_we pulse exactly 2 cycles after accept, fb_addr=645, fb_data=5; idle returns to 1.
- Fill with fb_grant=0: 8 back-to-back plots → plot_ready drops after the 8th accept (7 in FIFO + 1 in output stage ⇒ ready low once count=8). Then release grant → all accepted pixels written in order, none lost or duplicated.
- Out-of-range plots (x=320, y=0) and (x=0, y=240) → no fb_we; drop_count=2 with the macro, 0 without.
- Corner (x=319, y=239) → fb_addr=76799.
- clear_req with colour 3'b111 while 3 pixels are queued:
  - the 3 pixels are written first;
  - then 76800 writes with addr 0..76799 and data 7;
  - plot_ready stays 0 throughout; idle=1 afterwards; write_count=76803.
- Grant toggling 1,0,1,0 during streaming → fb_addr/fb_data stable across stalled cycles. Then resetn=0 mid-clear → fb_we=0, idle=1, next plot is written normally.
